// File: rtl/tcam_lookup_ctrl.sv
// Sequencer in front of the TCAM wrapper: issues lookup/write/flush commands one at a time
// and holds lookup results. Optional statistics counters are built when TCAM_CTRL_STATS_EN is defined.
module tcam_lookup_ctrl #(
    parameter int ID_Width    = 4,
    parameter int AddressSize = 4,
    parameter int CMP_LAT     = 4,
    parameter int WR_LAT      = 2,
    parameter int FLU_LAT     = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [ID_Width-1:0]      req_id,
    input  logic [ID_Width-1:0]      req_dst,
    input  logic [2*ID_Width-1:0]    req_mask,
    input  logic [AddressSize-1:0]   req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_Width-1:0]      rsp_id,
    output logic [ID_Width-1:0]      rsp_dst,
    output logic                     rsp_hit,
    output logic                     bad_op,
    output logic [2:0]               mem_mode,
    output logic [ID_Width-1:0]      mem_pkt_id,
    output logic [2*ID_Width-1:0]    mem_data,
    output logic [2*ID_Width-1:0]    mem_mskb,
    output logic [AddressSize-1:0]   mem_addr,
    output logic                     mem_vbe,
    output logic                     mem_dcs,
    output logic                     mem_vbi,
    input  logic [ID_Width-1:0]      mem_dst_id,
    output logic [15:0]              stat_lookups,
    output logic [15:0]              stat_hits
);

    localparam int MAX_LAT = (CMP_LAT > WR_LAT) ? ((CMP_LAT > FLU_LAT) ? CMP_LAT : FLU_LAT)
                                                : ((WR_LAT > FLU_LAT) ? WR_LAT : FLU_LAT);
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    localparam logic [1:0] OP_LOOKUP = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_FLUSH  = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    localparam logic [2:0] MODE_IDLE  = 3'b000;
    localparam logic [2:0] MODE_WR    = 3'b001;
    localparam logic [2:0] MODE_FLUSH = 3'b011;
    localparam logic [2:0] MODE_CMP   = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W-1:0]        cnt_nxt_s;
    logic [1:0]              op_r;
    logic [ID_Width-1:0]     id_r;
    logic                    accept_s;
    logic                    capture_s;
    logic                    rsp_done_s;

    logic                    req_ready_r;
    logic                    rsp_valid_r;
    logic [ID_Width-1:0]     rsp_id_r;
    logic [ID_Width-1:0]     rsp_dst_r;
    logic                    rsp_hit_r;
    logic                    bad_op_r;
    logic [2:0]              mem_mode_r;
    logic [ID_Width-1:0]     mem_pkt_id_r;
    logic [2*ID_Width-1:0]   mem_data_r;
    logic [2*ID_Width-1:0]   mem_mskb_r;
    logic [AddressSize-1:0]  mem_addr_r;
    logic                    mem_vbe_r;
    logic                    mem_dcs_r;
    logic                    mem_vbi_r;

    // Next-state logic and per-cycle event strobes.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        accept_s    = 1'b0;
        capture_s   = 1'b0;
        rsp_done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid && req_ready_r) begin
                    accept_s = 1'b1;
                    if (req_op == OP_RSVD) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_ISSUE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_nxt_s = ST_WAIT;
                case (op_r)
                    OP_LOOKUP: cnt_nxt_s = CNT_W'(CMP_LAT - 1);
                    OP_WRITE:  cnt_nxt_s = CNT_W'(WR_LAT - 1);
                    default:   cnt_nxt_s = CNT_W'(FLU_LAT - 1);
                endcase
            end
            ST_WAIT: begin
                if (cnt_r == '0) begin
                    if (op_r == OP_LOOKUP) begin
                        capture_s   = 1'b1;
                        state_nxt_s = ST_RESP;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_done_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, wait counter and ready flag; ready is held low for the cycle following reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            req_ready_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            req_ready_r <= (state_nxt_s == ST_IDLE);
        end
    end

    // Request latch: op selects the wait length and result handling, id is echoed in the response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_r <= 2'b00;
            id_r <= '0;
        end else if (accept_s) begin
            op_r <= req_op;
            id_r <= req_id;
        end
    end

    // Command port: loaded straight from the request so it is live only during ISSUE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_mode_r   <= MODE_IDLE;
            mem_pkt_id_r <= '0;
            mem_data_r   <= '0;
            mem_mskb_r   <= '0;
            mem_addr_r   <= '0;
            mem_vbe_r    <= 1'b0;
            mem_dcs_r    <= 1'b0;
            mem_vbi_r    <= 1'b0;
        end else begin
            mem_mode_r   <= MODE_IDLE;
            mem_pkt_id_r <= '0;
            mem_data_r   <= '0;
            mem_mskb_r   <= '0;
            mem_addr_r   <= '0;
            mem_vbe_r    <= 1'b0;
            mem_dcs_r    <= 1'b0;
            mem_vbi_r    <= 1'b0;
            if (accept_s) begin
                case (req_op)
                    OP_LOOKUP: begin
                        mem_mode_r   <= MODE_CMP;
                        mem_pkt_id_r <= req_id;
                    end
                    OP_WRITE: begin
                        mem_mode_r <= MODE_WR;
                        mem_data_r <= {req_id, req_dst};
                        mem_mskb_r <= req_mask;
                        mem_addr_r <= req_addr;
                        mem_vbe_r  <= 1'b1;
                        mem_dcs_r  <= 1'b1;
                        mem_vbi_r  <= 1'b1;
                    end
                    OP_FLUSH: begin
                        mem_mode_r <= MODE_FLUSH;
                    end
                    default: begin
                        mem_mode_r <= MODE_IDLE;
                    end
                endcase
            end
        end
    end

    // Held lookup response; fields stay put until the consumer takes them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            rsp_dst_r   <= '0;
            rsp_hit_r   <= 1'b0;
        end else if (capture_s) begin
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= id_r;
            rsp_dst_r   <= mem_dst_id;
            rsp_hit_r   <= (mem_dst_id != '0);
        end else if (rsp_done_s) begin
            rsp_valid_r <= 1'b0;
        end
    end

    // Reserved-op indication, one cycle after acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bad_op_r <= 1'b0;
        end else begin
            bad_op_r <= accept_s && (req_op == OP_RSVD);
        end
    end

`ifdef TCAM_CTRL_STATS_EN
    logic [15:0] stat_lookups_r;
    logic [15:0] stat_hits_r;

    // Saturating lookup and hit counters, advanced on each result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_lookups_r <= 16'h0000;
            stat_hits_r    <= 16'h0000;
        end else if (capture_s) begin
            if (stat_lookups_r != 16'hFFFF) begin
                stat_lookups_r <= stat_lookups_r + 16'h0001;
            end
            if ((mem_dst_id != '0) && (stat_hits_r != 16'hFFFF)) begin
                stat_hits_r <= stat_hits_r + 16'h0001;
            end
        end
    end

    assign stat_lookups = stat_lookups_r;
    assign stat_hits    = stat_hits_r;
`else
    assign stat_lookups = 16'h0000;
    assign stat_hits    = 16'h0000;
`endif

    assign req_ready  = req_ready_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_dst    = rsp_dst_r;
    assign rsp_hit    = rsp_hit_r;
    assign bad_op     = bad_op_r;
    assign mem_mode   = mem_mode_r;
    assign mem_pkt_id = mem_pkt_id_r;
    assign mem_data   = mem_data_r;
    assign mem_mskb   = mem_mskb_r;
    assign mem_addr   = mem_addr_r;
    assign mem_vbe    = mem_vbe_r;
    assign mem_dcs    = mem_dcs_r;
    assign mem_vbi    = mem_vbi_r;

endmodule

// File: tb/tb_tcam_lookup_ctrl.sv
// Scoreboard bench for tcam_lookup_ctrl: a table-level TCAM model answers compares and
// predicts responses, while independent monitors check commands, responses and bad_op pulses.
module tb_tcam_lookup_ctrl;

    localparam int CMP_LAT = 4;
    localparam int WR_LAT  = 2;
    localparam int FLU_LAT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'b00;
    logic [3:0] req_id = 4'h0;
    logic [3:0] req_dst = 4'h0;
    logic [7:0] req_mask = 8'h00;
    logic [3:0] req_addr = 4'h0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_id;
    logic [3:0] rsp_dst;
    logic       rsp_hit;
    logic       bad_op;
    logic [2:0] mem_mode;
    logic [3:0] mem_pkt_id;
    logic [7:0] mem_data;
    logic [7:0] mem_mskb;
    logic [3:0] mem_addr;
    logic       mem_vbe;
    logic       mem_dcs;
    logic       mem_vbi;
    logic [3:0] mem_dst_id = 4'h0;
    logic [15:0] stat_lookups;
    logic [15:0] stat_hits;

    tcam_lookup_ctrl #(
        .ID_Width(4), .AddressSize(4), .CMP_LAT(CMP_LAT), .WR_LAT(WR_LAT), .FLU_LAT(FLU_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_id(req_id),
        .req_dst(req_dst), .req_mask(req_mask), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_dst(rsp_dst),
        .rsp_hit(rsp_hit), .bad_op(bad_op),
        .mem_mode(mem_mode), .mem_pkt_id(mem_pkt_id), .mem_data(mem_data), .mem_mskb(mem_mskb),
        .mem_addr(mem_addr), .mem_vbe(mem_vbe), .mem_dcs(mem_dcs), .mem_vbi(mem_vbi),
        .mem_dst_id(mem_dst_id), .stat_lookups(stat_lookups), .stat_hits(stat_hits)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total_cnt = 0;
    int pass_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        if (got === exp) pass_cnt = pass_cnt + 1;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Abstract TCAM contents: lowest matching valid address wins; mask upper half = care bits.
    logic [3:0] t_key [16];
    logic [3:0] t_dst [16];
    logic [3:0] t_msk [16];
    bit         t_vld [16];

    function automatic logic [3:0] tcam_find(input logic [3:0] key);
        for (int a = 0; a < 16; a++)
            if (t_vld[a] && (((key ^ t_key[a]) & t_msk[a]) == 4'h0)) return t_dst[a];
        return 4'h0;
    endfunction

    typedef struct {
        logic [2:0] mode; logic [3:0] pkt; logic [7:0] data; logic [7:0] mskb;
        logic [3:0] addr; logic v; int acc;
    } cmd_t;
    typedef struct { logic [3:0] id; logic [3:0] dst; logic hit; int acc; int hold; } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    int   bad_q[$];

    // Memory side: the answer is only valid on the exact sample cycle, its complement elsewhere.
    int         age = 100;
    logic [3:0] res_m = 4'h0;
    always @(negedge clk) begin
        if (mem_mode == 3'b100) begin
            res_m = tcam_find(mem_pkt_id);
            age   = 0;
        end else if (age < 100) begin
            age = age + 1;
        end
        mem_dst_id = (age == CMP_LAT) ? res_m : ~res_m;
    end

    // Command monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_mode != 3'b000) begin
                if (cmd_q.size() == 0) begin
                    chk("unexpected_cmd", {29'd0, mem_mode}, 32'd0);
                end else begin
                    cmd_t c;
                    c = cmd_q.pop_front();
                    chk("cmd_mode", {29'd0, mem_mode}, {29'd0, c.mode});
                    chk("cmd_cycle", cyc, c.acc);
                    chk("cmd_fields", {mem_pkt_id, mem_data, mem_mskb, mem_addr, mem_vbe, mem_dcs, mem_vbi},
                        {c.pkt, c.data, c.mskb, c.addr, c.v, c.v, c.v});
                end
            end else begin
                chk("idle_fields", {5'd0, mem_pkt_id, mem_data, mem_mskb, mem_addr, mem_vbe, mem_dcs, mem_vbi}, 32'd0);
            end
            if (bad_op) begin
                if (bad_q.size() == 0) chk("unexpected_bad_op", 32'd1, 32'd0);
                else chk("bad_op_cycle", cyc, bad_q.pop_front());
            end
        end
    end

    // Response monitor; also owns rsp_ready so consumption timing is deterministic.
    bit   held = 1'b0;
    int   wait_cnt = 0;
    rsp_t cur;
    int   exp_lk = 0;
    int   exp_ht = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0; wait_cnt = 0; exp_lk = 0; exp_ht = 0;
            rsp_ready = 1'b0;
        end else begin
            if (held && rsp_ready) begin
                chk("rsp_drop_after_take", {31'd0, rsp_valid}, 32'd0);
                chk("ready_after_take", {31'd0, req_ready}, 32'd1);
                held = 1'b0;
            end
            if (rsp_valid) begin
                if (!held) begin
                    if (rsp_q.size() == 0) begin
                        chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
                    end else begin
                        cur = rsp_q.pop_front();
                        held = 1'b1;
                        wait_cnt = cur.hold;
                        chk("rsp_id", {28'd0, rsp_id}, {28'd0, cur.id});
                        chk("rsp_dst", {28'd0, rsp_dst}, {28'd0, cur.dst});
                        chk("rsp_hit", {31'd0, rsp_hit}, {31'd0, cur.hit});
                        chk("rsp_latency", cyc - cur.acc, CMP_LAT + 1);
                        exp_lk = exp_lk + 1;
                        if (cur.hit) exp_ht = exp_ht + 1;
`ifdef TCAM_CTRL_STATS_EN
                        chk("stat_lookups", {16'd0, stat_lookups}, exp_lk);
                        chk("stat_hits", {16'd0, stat_hits}, exp_ht);
`else
                        chk("stat_lookups", {16'd0, stat_lookups}, 32'd0);
                        chk("stat_hits", {16'd0, stat_hits}, 32'd0);
`endif
                    end
                end else begin
                    chk("rsp_stable", {23'd0, rsp_id, rsp_dst, rsp_hit}, {23'd0, cur.id, cur.dst, cur.hit});
                end
                chk("ready_low_in_resp", {31'd0, req_ready}, 32'd0);
            end else if (held) begin
                chk("rsp_dropped", {31'd0, rsp_valid}, 32'd1);
                held = 1'b0;
            end
            rsp_ready = held && (wait_cnt == 0);
            if (held && wait_cnt > 0) wait_cnt = wait_cnt - 1;
        end
    end

    task automatic send(input logic [1:0] op, input logic [3:0] id, input logic [3:0] dst,
                        input logic [7:0] mask, input logic [3:0] addr, input int hold,
                        output int acc);
        int   n;
        cmd_t c;
        rsp_t r;
        @(negedge clk);
        req_op = op; req_id = id; req_dst = dst; req_mask = mask; req_addr = addr;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n = n + 1;
        end
        acc = cyc + 1;
        if (!req_ready) begin
            chk("req_ready_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        c.mode = 3'b000; c.pkt = 4'h0; c.data = 8'h00; c.mskb = 8'h00; c.addr = 4'h0; c.v = 1'b0; c.acc = acc;
        case (op)
            2'b00: begin
                c.mode = 3'b100; c.pkt = id; cmd_q.push_back(c);
                r.id = id; r.dst = tcam_find(id); r.hit = (r.dst != 4'h0); r.acc = acc; r.hold = hold;
                rsp_q.push_back(r);
            end
            2'b01: begin
                c.mode = 3'b001; c.data = {id, dst}; c.mskb = mask; c.addr = addr; c.v = 1'b1;
                cmd_q.push_back(c);
                t_key[addr] = id; t_dst[addr] = dst; t_msk[addr] = mask[7:4]; t_vld[addr] = 1'b1;
            end
            2'b10: begin
                c.mode = 3'b011; cmd_q.push_back(c);
                for (int a = 0; a < 16; a++) t_vld[a] = 1'b0;
            end
            default: bad_q.push_back(acc);
        endcase
        @(negedge clk);
        req_valid = 1'b0;
        req_op = 2'($urandom); req_id = 4'($urandom); req_dst = 4'($urandom);
        req_mask = 8'($urandom); req_addr = 4'($urandom);
        if (op == 2'b01 || op == 2'b10) begin
            n = 0;
            while (!req_ready && n < 50) begin
                @(negedge clk);
                n = n + 1;
            end
            chk(op == 2'b01 ? "write_ready_return" : "flush_ready_return", cyc - acc,
                (op == 2'b01 ? WR_LAT : FLU_LAT) + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int acc;
        int r;
        logic [1:0] op;
        logic [3:0] k;
        for (int a = 0; a < 16; a++) begin
            t_key[a] = 4'h0; t_dst[a] = 4'h0; t_msk[a] = 4'h0; t_vld[a] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("reset_req_ready", {31'd0, req_ready}, 32'd0);
        chk("reset_rsp", {22'd0, rsp_valid, rsp_id, rsp_dst, rsp_hit, bad_op}, 32'd0);
        chk("reset_mem_mode", {29'd0, mem_mode}, 32'd0);
        chk("reset_stats", {stat_lookups, stat_hits}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("req_ready_after_reset", {31'd0, req_ready}, 32'd1);

        send(2'b01, 4'd5, 4'd9, 8'hFF, 4'd3, 0, acc);
        send(2'b00, 4'd5, 4'd0, 8'h00, 4'd0, 5, acc);
        send(2'b00, 4'd7, 4'd0, 8'h00, 4'd0, 0, acc);
        send(2'b10, 4'd0, 4'd0, 8'h00, 4'd0, 0, acc);
        send(2'b11, 4'd0, 4'd0, 8'h00, 4'd0, 0, acc);

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 99);
            op = (r < 50) ? 2'b00 : (r < 78) ? 2'b01 : (r < 88) ? 2'b10 : 2'b11;
            k = 4'($urandom_range(0, 7));
            send(op, k, 4'($urandom), ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom),
                 4'($urandom), $urandom_range(0, 3), acc);
        end

        send(2'b00, 4'd3, 4'd0, 8'h00, 4'd0, 0, acc);
        @(negedge clk);
        rst_n = 1'b0;
        rsp_q.delete();
        cmd_q.delete();
        @(negedge clk);
        chk("abort_mem_mode", {29'd0, mem_mode}, 32'd0);
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_req_ready", {31'd0, req_ready}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_abort", {31'd0, req_ready}, 32'd1);
        repeat (CMP_LAT + 6) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            op = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b01;
            send(op, 4'($urandom_range(0, 7)), 4'($urandom), 8'hFF, 4'($urandom), $urandom_range(0, 2), acc);
        end

        for (int n = 0; n < 200 && !(req_ready && !rsp_valid); n++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("rsp_queue_drained", rsp_q.size(), 32'd0);
        chk("cmd_queue_drained", cmd_q.size(), 32'd0);
        chk("bad_queue_drained", bad_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
